// File: rtl/hdmi_frame_sequencer.sv
// Raster timing and pixel sequencing for the three TMDS encoders of one HDMI/DVI output.
// Optional: define HDMI_SEQ_UNDERFLOW_CNT_EN to add the saturating underflow_count_out counter.
module hdmi_frame_sequencer #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  HW       = $clog2(H_TOTAL),
    localparam int  VW       = $clog2(V_TOTAL)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          enable_in,
    input  logic          pix_valid_in,
    input  logic [23:0]   pix_data_in,
    output logic          pix_ready_out,
    output logic [7:0]    red_out,
    output logic [7:0]    green_out,
    output logic [7:0]    blue_out,
    output logic          ve_out,
    output logic [1:0]    ctrl_blue_out,
    output logic [HW-1:0] hcount_out,
    output logic [VW-1:0] vcount_out,
    output logic          new_frame_out,
`ifdef HDMI_SEQ_UNDERFLOW_CNT_EN
    output logic [15:0]   underflow_count_out,
`endif
    output logic          underflow_out
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [HW-1:0] h;
    logic [VW-1:0] v;

    logic active;
    logic hs_on;
    logic vs_on;
    logic h_last;
    logic v_last;
    logic xfer;
    logic starve;

    assign active = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
    assign hs_on  = (int'(h) >= H_ACTIVE + H_FP) &&
                    (int'(h) <  H_ACTIVE + H_FP + H_SYNC);
    assign vs_on  = (int'(v) >= V_ACTIVE + V_FP) &&
                    (int'(v) <  V_ACTIVE + V_FP + V_SYNC);
    assign h_last = (int'(h) == H_TOTAL - 1);
    assign v_last = (int'(v) == V_TOTAL - 1);

    assign pix_ready_out = (state != IDLE) && active;
    assign xfer          = pix_ready_out && pix_valid_in;
    assign starve        = pix_ready_out && !pix_valid_in;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            h             <= '0;
            v             <= '0;
            red_out       <= '0;
            green_out     <= '0;
            blue_out      <= '0;
            ve_out        <= 1'b0;
            ctrl_blue_out <= {~VS_POL, ~HS_POL};
            hcount_out    <= '0;
            vcount_out    <= '0;
            new_frame_out <= 1'b0;
            underflow_out <= 1'b0;
`ifdef HDMI_SEQ_UNDERFLOW_CNT_EN
            underflow_count_out <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    h             <= '0;
                    v             <= '0;
                    red_out       <= '0;
                    green_out     <= '0;
                    blue_out      <= '0;
                    ve_out        <= 1'b0;
                    ctrl_blue_out <= {~VS_POL, ~HS_POL};
                    hcount_out    <= '0;
                    vcount_out    <= '0;
                    new_frame_out <= 1'b0;
                    if (enable_in) state <= RUN;
                end
                RUN, DRAIN: begin
                    // Sync levels are inactive inside the active region, so this covers both
                    ctrl_blue_out <= {vs_on ? VS_POL : ~VS_POL,
                                      hs_on ? HS_POL : ~HS_POL};
                    ve_out        <= active;
                    red_out       <= xfer ? pix_data_in[23:16] : 8'h00;
                    green_out     <= xfer ? pix_data_in[15:8]  : 8'h00;
                    blue_out      <= xfer ? pix_data_in[7:0]   : 8'h00;
                    hcount_out    <= h;
                    vcount_out    <= v;
                    new_frame_out <= (h == '0) && (v == '0);
                    if (starve) underflow_out <= 1'b1;
`ifdef HDMI_SEQ_UNDERFLOW_CNT_EN
                    if (starve && underflow_count_out != 16'hFFFF)
                        underflow_count_out <= underflow_count_out + 16'd1;
`endif
                    if (h_last) begin
                        h <= '0;
                        v <= v_last ? '0 : v + VW'(1);
                    end else begin
                        h <= h + HW'(1);
                    end
                    if (state == RUN) begin
                        if (!enable_in) state <= DRAIN;
                    end else if (enable_in) begin
                        state <= RUN;
                    end else if (h_last && v_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_frame_sequencer.sv
// Directed bench for hdmi_frame_sequencer on an 8x5 (40-cycle) test raster.
module tb_hdmi_frame_sequencer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        ve;
    logic [1:0]  ctrl_blue;
    logic [2:0]  hcount;
    logic [2:0]  vcount;
    logic        new_frame;
    logic        underflow;
`ifdef HDMI_SEQ_UNDERFLOW_CNT_EN
    logic [15:0] underflow_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    hdmi_frame_sequencer #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .enable_in     (enable),
        .pix_valid_in  (pix_valid),
        .pix_data_in   (pix_data),
        .pix_ready_out (pix_ready),
        .red_out       (red),
        .green_out     (green),
        .blue_out      (blue),
        .ve_out        (ve),
        .ctrl_blue_out (ctrl_blue),
        .hcount_out    (hcount),
        .vcount_out    (vcount),
        .new_frame_out (new_frame),
`ifdef HDMI_SEQ_UNDERFLOW_CNT_EN
        .underflow_count_out (underflow_count),
`endif
        .underflow_out (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for raster index idx (0..39) of the 8x5 test frame
    task automatic check_pos(input int idx, input logic [23:0] data,
                             input bit uf, input bit starved);
        int hx;
        int vx;
        logic       ve_e;
        logic [1:0] ctrl_e;
        logic [23:0] rgb_e;
        hx = idx % 8;
        vx = idx / 8;
        ve_e = (hx < 4) && (vx < 2);
        if (hx == 5 || hx == 6) ctrl_e = (vx == 3) ? 2'b11 : 2'b01;
        else                    ctrl_e = (vx == 3) ? 2'b10 : 2'b00;
        rgb_e = (ve_e && !starved) ? data : 24'h0;
        chk($sformatf("hcount@%0d", idx), 32'(hcount), 32'(hx));
        chk($sformatf("vcount@%0d", idx), 32'(vcount), 32'(vx));
        chk($sformatf("ve@%0d", idx), 32'(ve), 32'(ve_e));
        chk($sformatf("ctrl@%0d", idx), 32'(ctrl_blue), 32'(ctrl_e));
        chk($sformatf("rgb@%0d", idx), {8'h0, red, green, blue}, 32'(rgb_e));
        chk($sformatf("newframe@%0d", idx), 32'(new_frame), 32'(idx == 0));
        chk($sformatf("underflow@%0d", idx), 32'(underflow), 32'(uf));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ve"}, 32'(ve), 32'd0);
        chk({tag, "_ctrl"}, 32'(ctrl_blue), 32'd0);
        chk({tag, "_rgb"}, {8'h0, red, green, blue}, 32'd0);
        chk({tag, "_hcount"}, 32'(hcount), 32'd0);
        chk({tag, "_vcount"}, 32'(vcount), 32'd0);
        chk({tag, "_newframe"}, 32'(new_frame), 32'd0);
        chk({tag, "_ready"}, 32'(pix_ready), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 24'h0;
        step();
        step();
        check_idle("reset");
        chk("reset_underflow", 32'(underflow), 32'd0);

        // Start: first RUN cycle processes (0,0), outputs show it one cycle later
        rst_n     = 1'b1;
        enable    = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 24'h112233;
        step();
        chk("ready_first_run", 32'(pix_ready), 32'd1);
        step();
        check_pos(0, 24'h112233, 1'b0, 1'b0);
        chk("red_first", 32'(red), 32'h11);
        chk("green_first", 32'(green), 32'h22);
        chk("blue_first", 32'(blue), 32'h33);

        // Two frames; second frame uses new data and starves pixel (2,1)
        for (int k = 1; k < 80; k++) begin
            step();
            check_pos(k % 40, (k >= 40) ? 24'hA5C30F : 24'h112233,
                      k >= 50, k == 50);
`ifdef HDMI_SEQ_UNDERFLOW_CNT_EN
            if (k == 51) chk("uf_count", 32'(underflow_count), 32'd1);
`endif
            pix_valid = (k != 49);
            if (k == 39) pix_data = 24'hA5C30F;
        end

        // Drop enable while (1,0) is processed; frame completes then IDLE
        step();
        check_pos(0, 24'hA5C30F, 1'b1, 1'b0);
        enable = 1'b0;
        for (int k = 1; k < 40; k++) begin
            step();
            check_pos(k, 24'hA5C30F, 1'b1, 1'b0);
        end
        step();
        check_idle("drained");
        step();
        check_idle("idle_hold");
        chk("idle_underflow", 32'(underflow), 32'd1);

        // Restart, then drop and re-raise enable inside the frame: no gap
        enable = 1'b1;
        step();
        for (int k = 0; k <= 49; k++) begin
            step();
            check_pos(k % 40, 24'hA5C30F, 1'b1, 1'b0);
            if (k == 5)  enable = 1'b0;
            if (k == 20) enable = 1'b1;
        end

        // Reset while (2,1) is processed: aborts immediately
        rst_n = 1'b0;
        step();
        check_idle("midreset");
        chk("midreset_underflow", 32'(underflow), 32'd0);
        rst_n = 1'b1;
        step();
        step();
        check_pos(0, 24'hA5C30F, 1'b0, 1'b0);
        step();
        check_pos(1, 24'hA5C30F, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
